// File: rtl/design6_share_arb.sv
// design6_share_arb
//   Round-robin arbiter that shares a single design6_seq 4-operand sequential
//   adder among NREQ requesters. A granted requester's operands are latched,
//   the adder is started with a one-cycle pulse, and the adder's result is
//   returned to that requester together with a one-cycle done pulse. A
//   watchdog aborts the operation (result 0, err pulse) if the adder never
//   answers.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        asynchronous active-high reset
//   req        per-requester request level, held until the matching done
//   a_in..d_in packed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt        one-hot grant, high from ISSUE through RESP
//   done       one-hot single-cycle completion pulse
//   err        single-cycle timeout flag, coincident with done
//   result     sum returned to the requester, held until the next completion
//   add_start  start pulse to the adder
//   add_a..d   registered operands to the adder
//   add_f      adder result
//   add_valid  adder result valid
module design6_share_arb #(
  parameter int WIDTH   = 4,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   a_in,
  input  logic [NREQ*WIDTH-1:0]   b_in,
  input  logic [NREQ*WIDTH-1:0]   c_in,
  input  logic [NREQ*WIDTH-1:0]   d_in,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    err,
  output logic [WIDTH+1:0]        result,
  output logic                    add_start,
  output logic [WIDTH-1:0]        add_a,
  output logic [WIDTH-1:0]        add_b,
  output logic [WIDTH-1:0]        add_c,
  output logic [WIDTH-1:0]        add_d,
  input  logic [WIDTH+1:0]        add_f,
  input  logic                    add_valid
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   idx;
  logic            found;
  logic [WW-1:0]   wdog;
  logic            err_flag;
  logic            timeout_hit;

  // Round-robin search: first active request at or above ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // The watchdog has already counted TIMEOUT-1 idle WAIT cycles; this one is the last.
  assign timeout_hit = (wdog == WW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    done      = '0;
    err       = 1'b0;
    add_start = 1'b0;
    case (state)
      IDLE: begin
        // A stale add_valid left over from the adder must not be mistaken
        // for the answer to a new operation, so granting waits it out.
        if (found && !add_valid) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        gnt       = NREQ'(1) << sel;
        add_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        gnt = NREQ'(1) << sel;
        if (add_valid || timeout_hit) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        gnt       = NREQ'(1) << sel;
        done      = NREQ'(1) << sel;
        err       = err_flag;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      sel      <= '0;
      wdog     <= '0;
      err_flag <= 1'b0;
      result   <= '0;
      add_a    <= '0;
      add_b    <= '0;
      add_c    <= '0;
      add_d    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (state_nxt == ISSUE) begin
            sel   <= pick;
            add_a <= a_in[int'(pick)*WIDTH +: WIDTH];
            add_b <= b_in[int'(pick)*WIDTH +: WIDTH];
            add_c <= c_in[int'(pick)*WIDTH +: WIDTH];
            add_d <= d_in[int'(pick)*WIDTH +: WIDTH];
          end
        end
        ISSUE: begin
          wdog     <= '0;
          err_flag <= 1'b0;
        end
        WAIT: begin
          if (add_valid) begin
            result <= add_f;
          end else begin
            wdog <= wdog + WW'(1);
            if (timeout_hit) begin
              result   <= '0;
              err_flag <= 1'b1;
            end
          end
        end
        RESP: begin
          ptr <= (sel == IW'(NREQ - 1)) ? '0 : sel + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
